// File: rtl/router_arbiter_rr_lock_if.sv
// Handshake bundle between input-side flit control and the output-port arbiter.
// master: flit control (drives request/head/tail); slave: the arbiter.
interface router_arbiter_rr_lock_if #(
   parameter int NUM_PORTS = 5
);
   localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] request;
   logic                 forwarding_head;
   logic                 forwarding_tail;
   logic [NUM_PORTS-1:0] grant;
   logic                 grant_valid;
   logic                 locked;
   logic [ID_W-1:0]      owner_id;
   logic                 protocol_error;
   logic                 wdog_expired;

   modport master (
      output request, forwarding_head, forwarding_tail,
      input  grant, grant_valid, locked, owner_id, protocol_error, wdog_expired
   );

   modport slave (
      input  request, forwarding_head, forwarding_tail,
      output grant, grant_valid, locked, owner_id, protocol_error, wdog_expired
   );
endinterface

// File: rtl/router_arbiter_rr_lock.sv
// N-input wormhole arbiter for a NoC router output port.
// Zero-latency least-recently-served grant (upper-triangle priority matrix),
// lock held on the owning port from head to tail, protocol error pulse.
// Optional lock watchdog enabled by defining ROUTER_ARB_LOCK_WDOG_EN.
module router_arbiter_rr_lock #(
   parameter int NUM_PORTS       = 5,
   parameter int MAX_LOCK_CYCLES = 256
) (
   input logic                      clk,
   input logic                      rst_n,
   router_arbiter_rr_lock_if.slave  arb_if
);
   localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int NPAIR = NUM_PORTS * (NUM_PORTS - 1) / 2;

   // Elaboration-time sanity on parameters.
   if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
      $error("router_arbiter_rr_lock: NUM_PORTS out of range 2..16");
   end
   if (MAX_LOCK_CYCLES < 2) begin : g_bad_max
      $error("router_arbiter_rr_lock: MAX_LOCK_CYCLES must be >= 2");
   end

   // Flat offset of pair (i,j), i<j, in the upper-triangle store.
   function automatic int pidx(input int i, input int j);
      return i * NUM_PORTS - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   logic [NPAIR-1:0]                      prio_q, prio_d;   // bit = P[i][j], i<j
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   beats;            // beats[i][j] = i beats j
   logic [NUM_PORTS-1:0]                  req, gnt_free, gnt, owner_oh;
   logic                                  gv, head, tail;
   logic                                  locked_q, locked_d;
   logic [ID_W-1:0]                       owner_q, owner_d, gnt_idx, demote_idx;
   logic                                  perr_q, perr_d;
   logic                                  tail_ok, lock_set, demote, wdog_hit;

   assign req  = arb_if.request;
   assign head = arb_if.forwarding_head;
   assign tail = arb_if.forwarding_tail;

   // Full matrix view: lower triangle is the complement of the stored half.
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_row
      for (genvar j = 0; j < NUM_PORTS; j++) begin : g_col
         if (i < j) begin : g_up
            assign beats[i][j] = prio_q[pidx(i, j)];
         end else if (i > j) begin : g_lo
            assign beats[i][j] = ~prio_q[pidx(j, i)];
         end else begin : g_diag
            assign beats[i][j] = 1'b0;
         end
      end
   end

   // Unlocked grant: a requester wins if no other requester beats it.
   always_comb begin
      logic blk;
      gnt_free = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         blk = 1'b0;
         for (int j = 0; j < NUM_PORTS; j++) blk = blk | (req[j] & beats[j][i]);
         gnt_free[i] = req[i] & ~blk;
      end
   end

   // Final grant: locked owner only (bubble if it drops its request).
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      gnt               = locked_q ? (owner_oh & req) : gnt_free;
      gv                = locked_q ? req[owner_q] : (|req);
      gnt_idx           = '0;
      for (int i = 0; i < NUM_PORTS; i++) if (gnt[i]) gnt_idx = ID_W'(i);
   end

`ifdef ROUTER_ARB_LOCK_WDOG_EN
   localparam int CNT_W = $clog2(MAX_LOCK_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wdog_q;
`endif

   // Next-state decode: error detection, lock set/clear, priority demotion.
   always_comb begin
      perr_d   = (head & locked_q) | ((head | tail) & ~gv) | (tail & ~locked_q & ~head);
      tail_ok  = tail & gv & ~perr_d;
      lock_set = head & ~tail & gv & ~locked_q;
`ifdef ROUTER_ARB_LOCK_WDOG_EN
      // A legal tail in the expiry cycle wins: plain unlock, no expiry.
      wdog_hit = locked_q & (cnt_q == CNT_W'(MAX_LOCK_CYCLES - 1)) & ~tail_ok;
`else
      wdog_hit = 1'b0;
`endif
      demote     = tail_ok | wdog_hit;
      demote_idx = locked_q ? owner_q : gnt_idx;

      locked_d = locked_q;
      if (lock_set) locked_d = 1'b1;
      if (locked_q & (tail_ok | wdog_hit)) locked_d = 1'b0;

      owner_d = owner_q;
      if (head & gv & ~locked_q) owner_d = gnt_idx;

      prio_d = prio_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = i + 1; j < NUM_PORTS; j++) begin
            if (demote && demote_idx == ID_W'(i)) prio_d[pidx(i, j)] = 1'b0;
            else if (demote && demote_idx == ID_W'(j)) prio_d[pidx(i, j)] = 1'b1;
         end
      end
`ifdef ROUTER_ARB_LOCK_WDOG_EN
      cnt_d = (locked_q & locked_d) ? cnt_q + 1'b1 : '0;
`endif
   end

   // State registers; reset gives port 0 highest, unlocked, owner 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q   <= '1;
         locked_q <= 1'b0;
         owner_q  <= '0;
         perr_q   <= 1'b0;
`ifdef ROUTER_ARB_LOCK_WDOG_EN
         cnt_q    <= '0;
         wdog_q   <= 1'b0;
`endif
      end else begin
         prio_q   <= prio_d;
         locked_q <= locked_d;
         owner_q  <= owner_d;
         perr_q   <= perr_d;
`ifdef ROUTER_ARB_LOCK_WDOG_EN
         cnt_q    <= cnt_d;
         wdog_q   <= wdog_hit;
`endif
      end
   end

   assign arb_if.grant          = gnt;
   assign arb_if.grant_valid    = gv;
   assign arb_if.locked         = locked_q;
   assign arb_if.owner_id       = owner_q;
   assign arb_if.protocol_error = perr_q;
`ifdef ROUTER_ARB_LOCK_WDOG_EN
   assign arb_if.wdog_expired   = wdog_q;
`else
   assign arb_if.wdog_expired   = 1'b0;
`endif

`ifndef SYNTHESIS
   // Structural invariants of the grant and the priority matrix.
   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_subset  : assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == '0);
   a_owner   : assert property (@(posedge clk) disable iff (!rst_n)
                                 locked_q |-> ((gnt & ~owner_oh) == '0));
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_as_r
      for (genvar j = i + 1; j < NUM_PORTS; j++) begin : g_as_c
         a_anti : assert property (@(posedge clk) disable iff (!rst_n)
                                   beats[i][j] != beats[j][i]);
      end
   end
`endif
endmodule

// File: tb/tb_router_arbiter_rr_lock.sv
// Directed bench for router_arbiter_rr_lock, NUM_PORTS=5, MAX_LOCK_CYCLES=8.
module tb_router_arbiter_rr_lock;
   localparam int N = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   router_arbiter_rr_lock_if #(.NUM_PORTS(N)) arb_if ();

   router_arbiter_rr_lock #(.NUM_PORTS(N), .MAX_LOCK_CYCLES(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (arb_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq[6];
      seq = '{0, 1, 2, 3, 4, 0};
      rst_n = 1'b0;
      arb_if.request = '0;
      arb_if.forwarding_head = 1'b0;
      arb_if.forwarding_tail = 1'b0;

      // Reset state
      #3;
      chk("rst_grant", arb_if.grant, 0);
      chk("rst_locked", arb_if.locked, 0);
      chk("rst_owner", arb_if.owner_id, 0);
      chk("rst_perr", arb_if.protocol_error, 0);
      chk("rst_wdog", arb_if.wdog_expired, 0);
      #9 rst_n = 1'b1;
      tick();

      // Zero-latency unlocked grant
      arb_if.request = 5'b10110;
      #1;
      chk("unl_grant", arb_if.grant, 5'b00010);
      chk("unl_gv", arb_if.grant_valid, 1);
      chk("unl_locked", arb_if.locked, 0);

      // Lock on port 1, other requests ignored, then tail demotes port 1
      arb_if.forwarding_head = 1'b1;
      tick();
      arb_if.forwarding_head = 1'b0;
      arb_if.request = 5'b10100;
      #1;
      chk("lk_grant", arb_if.grant, 0);
      chk("lk_gv", arb_if.grant_valid, 0);
      chk("lk_locked", arb_if.locked, 1);
      chk("lk_owner", arb_if.owner_id, 1);
      chk("lk_perr", arb_if.protocol_error, 0);
      tick();
      tick();
      arb_if.request = 5'b10110;
      arb_if.forwarding_tail = 1'b1;
      #1;
      chk("lk_tail_grant", arb_if.grant, 5'b00010);
      tick();
      arb_if.forwarding_tail = 1'b0;
      #1;
      chk("unlk_locked", arb_if.locked, 0);
      chk("unlk_perr", arb_if.protocol_error, 0);
      chk("demote_grant", arb_if.grant, 5'b00100);

      // Async reset mid-packet (owner 2)
      arb_if.request = 5'b00100;
      arb_if.forwarding_head = 1'b1;
      tick();
      arb_if.forwarding_head = 1'b0;
      chk("pre_rst_locked", arb_if.locked, 1);
      chk("pre_rst_owner", arb_if.owner_id, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_locked", arb_if.locked, 0);
      chk("arst_owner", arb_if.owner_id, 0);
      arb_if.request = 5'b00101;
      #1;
      chk("arst_grant_a", arb_if.grant, 5'b00001);
      arb_if.request = 5'b00110;
      #1;
      chk("arst_grant_b", arb_if.grant, 5'b00010);
      rst_n = 1'b1;
      tick();

      // Back-to-back single-flit packets rotate through all ports
      arb_if.request = 5'b11111;
      arb_if.forwarding_head = 1'b1;
      arb_if.forwarding_tail = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("sf_grant%0d", k), arb_if.grant, 32'd1 << seq[k]);
         tick();
         chk($sformatf("sf_locked%0d", k), arb_if.locked, 0);
         chk($sformatf("sf_owner%0d", k), arb_if.owner_id, seq[k]);
         chk($sformatf("sf_perr%0d", k), arb_if.protocol_error, 0);
      end
      arb_if.forwarding_head = 1'b0;
      arb_if.forwarding_tail = 1'b0;

      // Lock on port 3, head while locked, tail with no grant
      arb_if.request = 5'b01000;
      arb_if.forwarding_head = 1'b1;
      #1;
      chk("p3_grant", arb_if.grant, 5'b01000);
      tick();
      chk("p3_locked", arb_if.locked, 1);
      chk("p3_owner", arb_if.owner_id, 3);
      tick();
      arb_if.forwarding_head = 1'b0;
      chk("hd_lk_perr", arb_if.protocol_error, 1);
      chk("hd_lk_locked", arb_if.locked, 1);
      chk("hd_lk_owner", arb_if.owner_id, 3);
      tick();
      chk("perr_pulse_end", arb_if.protocol_error, 0);
      arb_if.request = 5'b00000;
      arb_if.forwarding_tail = 1'b1;
      tick();
      chk("tl_nogv_perr", arb_if.protocol_error, 1);
      chk("tl_nogv_locked", arb_if.locked, 1);
      arb_if.request = 5'b01000;
      #1;
      chk("p3_tail_gv", arb_if.grant_valid, 1);
      tick();
      arb_if.forwarding_tail = 1'b0;
      chk("p3_unlocked", arb_if.locked, 0);
      chk("p3_tail_perr", arb_if.protocol_error, 0);
      arb_if.request = 5'b01001;
      #1;
      chk("p3_demoted", arb_if.grant, 5'b00001);
      arb_if.request = 5'b10001;
      #1;
      chk("prio_4_over_0", arb_if.grant, 5'b10000);

      // Tail while unlocked without head
      arb_if.forwarding_tail = 1'b1;
      tick();
      arb_if.forwarding_tail = 1'b0;
      #1;
      chk("tl_unl_perr", arb_if.protocol_error, 1);
      chk("tl_unl_locked", arb_if.locked, 0);
      chk("tl_unl_owner", arb_if.owner_id, 3);
      chk("tl_unl_prio", arb_if.grant, 5'b10000);

`ifdef ROUTER_ARB_LOCK_WDOG_EN
      // Watchdog expiry after 8 locked cycles
      arb_if.request = 5'b00100;
      arb_if.forwarding_head = 1'b1;
      tick();
      arb_if.forwarding_head = 1'b0;
      repeat (7) tick();
      chk("wd_still_locked", arb_if.locked, 1);
      chk("wd_not_yet", arb_if.wdog_expired, 0);
      tick();
      chk("wd_pulse", arb_if.wdog_expired, 1);
      chk("wd_unlocked", arb_if.locked, 0);
      arb_if.request = 5'b00101;
      #1;
      chk("wd_demote", arb_if.grant, 5'b00001);
      tick();
      chk("wd_pulse_end", arb_if.wdog_expired, 0);
      // Tail on the 8th locked cycle beats the watchdog
      arb_if.request = 5'b00100;
      arb_if.forwarding_head = 1'b1;
      tick();
      arb_if.forwarding_head = 1'b0;
      repeat (7) tick();
      arb_if.forwarding_tail = 1'b1;
      tick();
      arb_if.forwarding_tail = 1'b0;
      chk("wd_tail_unlocked", arb_if.locked, 0);
      chk("wd_tail_nopulse", arb_if.wdog_expired, 0);
      tick();
      chk("wd_tail_nopulse2", arb_if.wdog_expired, 0);
`else
      // Without the watchdog the lock holds indefinitely
      arb_if.request = 5'b00100;
      arb_if.forwarding_head = 1'b1;
      tick();
      arb_if.forwarding_head = 1'b0;
      repeat (12) tick();
      chk("nowd_locked", arb_if.locked, 1);
      chk("nowd_wdog", arb_if.wdog_expired, 0);
      chk("nowd_grant", arb_if.grant, 5'b00100);
      arb_if.forwarding_tail = 1'b1;
      tick();
      arb_if.forwarding_tail = 1'b0;
      chk("nowd_unlocked", arb_if.locked, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
